// File: rtl/dispatch_queue.sv
// dispatch_queue
//
// Small in-order instruction queue between fetch/decode and the back end.
// Decoded instructions are buffered in a circular FIFO and the head entry is
// issued to the ROB together with either the reservation station (RS) or the
// load/store buffer (LSB), selected by its optype. An issue only happens when
// the ROB and the selected unit can both accept, so a partial issue never
// occurs.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-low reset
//   rdy                global ready; low freezes every piece of state
//   flush              misprediction flush, empties the queue
//   in_valid/optype/payload, in_ready   enqueue handshake from fetch
//   rob_full, rob_next_tag              ROB back-pressure and tag to assign
//   rs_full, lsb_full                   RS / LSB back-pressure
//   rob_enable, rs_enable, lsb_enable, reg_rename_enable, issue_rd_tag
//                                       issue strobes and rename tag
//   out_optype, out_payload             head entry (valid when count != 0)
//   count                               occupancy
//   stall_cnt                           saturating resource-stall counter

module dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int OP_W = 6,
    parameter int PAYLOAD_W = 64,
    parameter int ROB_W = 4,
    parameter logic [OP_W-1:0] LS_LO = 6'd10,
    parameter logic [OP_W-1:0] LS_HI = 6'd17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [OP_W-1:0]           in_optype,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    output logic                      in_ready,
    input  logic                      rob_full,
    input  logic [ROB_W-1:0]          rob_next_tag,
    input  logic                      rs_full,
    input  logic                      lsb_full,
    output logic                      rob_enable,
    output logic                      rs_enable,
    output logic                      lsb_enable,
    output logic                      reg_rename_enable,
    output logic [ROB_W-1:0]          issue_rd_tag,
    output logic [OP_W-1:0]           out_optype,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [$clog2(DEPTH):0]    count,
    output logic [15:0]               stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OP_W-1:0]      op_mem  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    logic active;
    logic is_ls;
    logic unit_full;
    logic fire;
    logic enq;

    // Everything that moves state is gated by "active": out of reset, globally
    // ready and not flushing. Occupancy is compared against DEPTH before any
    // dequeue, so a full queue refuses an entry even if the head leaves now.
    always_comb begin
        active    = rst && rdy && !flush;
        in_ready  = active && (count < CNT_W'(DEPTH));
        enq       = in_valid && in_ready;
        out_optype  = op_mem[head];
        out_payload = pay_mem[head];
        is_ls     = (out_optype >= LS_LO) && (out_optype <= LS_HI);
        unit_full = is_ls ? lsb_full : rs_full;
        fire      = active && (count != '0) && !rob_full && !unit_full;
    end

    // Issue strobes all derive from the single fire term so the ROB and the
    // selected execution unit are always allocated together.
    always_comb begin
        rob_enable        = fire;
        reg_rename_enable = fire;
        rs_enable         = fire && !is_ls;
        lsb_enable        = fire && is_ls;
        issue_rd_tag      = fire ? rob_next_tag : '0;
    end

    // Entry storage is not reset; head/tail/count decide which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            op_mem[tail]  <= in_optype;
            pay_mem[tail] <= in_payload;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A flush empties
    // the queue but deliberately leaves stall_cnt alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)
                    tail <= tail + PTR_W'(1);
                if (fire)
                    head <= head + PTR_W'(1);
                if (enq && !fire)
                    count <= count + CNT_W'(1);
                else if (fire && !enq)
                    count <= count - CNT_W'(1);
                if ((count != '0) && !fire && (stall_cnt != 16'hFFFF))
                    stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue
//
// Drives dispatch_queue (default parameters) with a few directed sequences
// followed by randomized traffic, and compares every output against a
// queue-based reference model of the intended behaviour.

module tb_dispatch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic [5:0]  in_optype;
    logic [63:0] in_payload;
    logic        in_ready;
    logic        rob_full;
    logic [3:0]  rob_next_tag;
    logic        rs_full;
    logic        lsb_full;
    logic        rob_enable;
    logic        rs_enable;
    logic        lsb_enable;
    logic        reg_rename_enable;
    logic [3:0]  issue_rd_tag;
    logic [5:0]  out_optype;
    logic [63:0] out_payload;
    logic [2:0]  count;
    logic [15:0] stall_cnt;

    dispatch_queue dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .flush(flush),
        .in_valid(in_valid),
        .in_optype(in_optype),
        .in_payload(in_payload),
        .in_ready(in_ready),
        .rob_full(rob_full),
        .rob_next_tag(rob_next_tag),
        .rs_full(rs_full),
        .lsb_full(lsb_full),
        .rob_enable(rob_enable),
        .rs_enable(rs_enable),
        .lsb_enable(lsb_enable),
        .reg_rename_enable(reg_rename_enable),
        .issue_rd_tag(issue_rd_tag),
        .out_optype(out_optype),
        .out_payload(out_payload),
        .count(count),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [63:0] pl;
    } entry_t;

    entry_t model_q[$];
    int     model_stall;
    int     num_checks;
    int     num_fail;

    // Single point of comparison: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check combinational
    // outputs against the model, advance the model, then check registered
    // state after the rising edge.
    task automatic applyStimulus(input logic r, input logic rd, input logic fl,
                                 input logic iv, input logic [5:0] op,
                                 input logic [63:0] pl, input logic rf,
                                 input logic [3:0] tag, input logic sf,
                                 input logic lf);
        logic   act;
        logic   exp_ready;
        logic   head_ls;
        logic   exp_fire;
        int     sz;
        entry_t e;
        @(negedge clk);
        rst = r; rdy = rd; flush = fl; in_valid = iv; in_optype = op;
        in_payload = pl; rob_full = rf; rob_next_tag = tag; rs_full = sf;
        lsb_full = lf;
        #1;
        sz        = model_q.size();
        act       = r && rd && !fl;
        exp_ready = act && (sz < 4);
        head_ls   = (sz > 0) && (model_q[0].op >= 6'd10) && (model_q[0].op <= 6'd17);
        exp_fire  = act && (sz > 0) && !rf && (head_ls ? !lf : !sf);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("rob_enable", 64'(rob_enable), 64'(exp_fire));
        checkOutput("rename_enable", 64'(reg_rename_enable), 64'(exp_fire));
        checkOutput("rs_enable", 64'(rs_enable), 64'(exp_fire && !head_ls));
        checkOutput("lsb_enable", 64'(lsb_enable), 64'(exp_fire && head_ls));
        checkOutput("issue_rd_tag", 64'(issue_rd_tag), exp_fire ? 64'(tag) : 64'd0);
        if (sz > 0) begin
            checkOutput("out_optype", 64'(out_optype), 64'(model_q[0].op));
            checkOutput("out_payload", out_payload, model_q[0].pl);
        end
        if (!r) begin
            model_q.delete();
            model_stall = 0;
        end else if (rd) begin
            if (fl) begin
                model_q.delete();
            end else begin
                if (sz > 0 && !exp_fire && model_stall < 65535)
                    model_stall++;
                if (exp_fire)
                    void'(model_q.pop_front());
                if (iv && exp_ready) begin
                    e.op = op;
                    e.pl = pl;
                    model_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("count", 64'(count), 64'(model_q.size()));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    endtask

    initial begin
        num_checks  = 0;
        num_fail    = 0;
        model_stall = 0;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_optype = '0; in_payload = '0; rob_full = 1'b0; rob_next_tag = '0;
        rs_full = 1'b0; lsb_full = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held: everything quiet and cleared.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd3, 64'h1, 1'b0, 4'd2, 1'b0, 1'b0);

        // Fill with RS ops while the RS is full: four accepted, fifth refused.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd3, 64'(100 + i), 1'b0, 4'd1, 1'b1, 1'b0);
        checkOutput("fill_count", 64'(count), 64'd4);

        // Flush with a pending enqueue empties the queue.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 6'd3, 64'h55, 1'b0, 4'd1, 1'b0, 1'b0);
        checkOutput("flush_count", 64'(count), 64'd0);

        // Routing: an LSB op then an RS op, tags 5 then 6.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd12, 64'hA, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd3,  64'hB, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  64'h0, 1'b0, 4'd6, 1'b0, 1'b0);

        // ROB full holds a single op, then it leaves as soon as the ROB frees.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd17, 64'hC, 1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  64'h0, 1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  64'h0, 1'b0, 4'd8, 1'b0, 1'b0);

        // Wrap: ten back-to-back ops with payloads 0..9 dispatching each cycle.
        for (int i = 0; i < 11; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, (i < 10), 6'(i * 2), 64'(i), 1'b0, 4'(i), 1'b0, 1'b0);

        // Two queued ops frozen by rdy=0, then a one-cycle reset.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 64'hD, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd2, 64'hE, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 64'hF, 1'b0, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd4, 64'hF, 1'b0, 4'd3, 1'b0, 1'b0);
        checkOutput("reset_stall", 64'(stall_cnt), 64'd0);
        // First enqueue after reset is taken immediately.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'd9, 64'h99, 1'b1, 4'd3, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(8, 19))
                                             : 6'($urandom_range(0, 63));
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 9) < 7),
                          op,
                          {32'($urandom), 32'($urandom)},
                          ($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fail);
        $finish;
    end

endmodule
